// File: rtl/thread_regfile_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : thread_regfile_bank_if
// Brief    : Decoder/scheduler/datapath bundle for the multi-lane register bank.
// Revision : 1.0  initial release
// ============================================================================
interface thread_regfile_bank_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS         = 8,
  parameter int NUM_REGS          = 16,
  parameter int BLOCK_ID_BITS     = 8
);
  localparam int AW = $clog2(NUM_REGS);

  logic [THREADS_PER_BLOCK-1:0]           thread_enable;
  logic                                   block_start;
  logic [BLOCK_ID_BITS-1:0]               block_id;
  logic [2:0]                             core_state;
  logic [AW-1:0]                          decoded_rd_address;
  logic [AW-1:0]                          decoded_rs_address;
  logic [AW-1:0]                          decoded_rt_address;
  logic                                   decoded_reg_write_enable;
  logic [1:0]                             decoded_reg_input_mux;
  logic [DATA_BITS-1:0]                   decoded_immediate;
  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] alu_out;
  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] lsu_out;
  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rs;
  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rt;
  logic                                   busy;
  logic                                   ready;

  modport master (
    output thread_enable, block_start, block_id, core_state,
           decoded_rd_address, decoded_rs_address, decoded_rt_address,
           decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
           alu_out, lsu_out,
    input  rs, rt, busy, ready
  );

  modport slave (
    input  thread_enable, block_start, block_id, core_state,
           decoded_rd_address, decoded_rs_address, decoded_rt_address,
           decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
           alu_out, lsu_out,
    output rs, rt, busy, ready
  );
endinterface
`default_nettype wire

// File: rtl/thread_regfile_bank.sv
`default_nettype none
// ============================================================================
// Module   : thread_regfile_bank
// Brief    : Register files of all thread lanes with block-start clear sequencer.
// Revision : 1.0  initial release
// ============================================================================
module thread_regfile_bank #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS         = 8,
  parameter int NUM_REGS          = 16,
  parameter int BLOCK_ID_BITS     = 8
) (
  input  wire                  clk,
  input  wire                  reset_n,
  thread_regfile_bank_if.slave bus
);
  localparam int AW  = $clog2(NUM_REGS);
  localparam int AWX = AW + 1;

  localparam logic [2:0]     c_REQUEST    = 3'd3;
  localparam logic [2:0]     c_UPDATE     = 3'd6;
  localparam logic [1:0]     c_MUX_ALU    = 2'b00;
  localparam logic [1:0]     c_MUX_LSU    = 2'b01;
  localparam logic [1:0]     c_MUX_IMM    = 2'b10;
  localparam logic [1:0]     c_MUX_NONE   = 2'b11;
  localparam logic [AWX-1:0] c_FREE_EXT   = AWX'(NUM_REGS - 3);
  localparam logic [AWX-1:0] c_BIDX_EXT   = AWX'(NUM_REGS - 3);
  localparam logic [AWX-1:0] c_BDIM_EXT   = AWX'(NUM_REGS - 2);
  localparam logic [AWX-1:0] c_TIDX_EXT   = AWX'(NUM_REGS - 1);
  localparam logic [AW-1:0]  c_CLEAR_LAST = AW'(NUM_REGS - 4);
  localparam logic [DATA_BITS-1:0] c_BLOCK_DIM = DATA_BITS'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [AW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_block_idx;
  logic [DATA_BITS-1:0] w_block_id;
  logic                 w_wr_en;
  logic                 w_rd_en;

  if (BLOCK_ID_BITS >= DATA_BITS) begin : g_bid_trunc
    assign w_block_id = bus.block_id[DATA_BITS-1:0];
  end else begin : g_bid_ext
    assign w_block_id = {{(DATA_BITS-BLOCK_ID_BITS){1'b0}}, bus.block_id};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.block_start) begin
      w_next_state = S_CLEAR;
    end else if ((r_state == S_CLEAR) && (r_cnt == c_CLEAR_LAST)) begin
      w_next_state = S_ACTIVE;
    end
  end

  // %blockIdx is shared by every lane, so one copy serves the whole bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_block_idx <= '0;
    end else if (bus.block_start) begin
      r_cnt       <= '0;
      r_block_idx <= w_block_id;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.busy = (r_state == S_CLEAR);
  assign bus.ready = (r_state == S_ACTIVE);

  assign w_rd_en = (r_state == S_ACTIVE) && !bus.block_start && (bus.core_state == c_REQUEST);
  assign w_wr_en = (r_state == S_ACTIVE) && !bus.block_start && (bus.core_state == c_UPDATE)
                   && bus.decoded_reg_write_enable && (bus.decoded_reg_input_mux != c_MUX_NONE)
                   && ({1'b0, bus.decoded_rd_address} < c_FREE_EXT);

  for (genvar t = 0; t < THREADS_PER_BLOCK; t++) begin : g_lane
    localparam logic [DATA_BITS-1:0] c_THREAD_IDX = DATA_BITS'(t);

    // Read-only slots of this array are never written and never read
    logic [DATA_BITS-1:0] r_regs [NUM_REGS];
    logic [DATA_BITS-1:0] r_rs;
    logic [DATA_BITS-1:0] r_rt;
    logic [AW-1:0]        w_addr [2];
    logic [DATA_BITS-1:0] w_val  [2];
    logic [DATA_BITS-1:0] w_wdata;

    assign w_addr[0] = bus.decoded_rs_address;
    assign w_addr[1] = bus.decoded_rt_address;

    always_comb begin
      for (int p = 0; p < 2; p++) begin
        w_val[p] = '0;
        if ({1'b0, w_addr[p]} < c_FREE_EXT) begin
          w_val[p] = r_regs[w_addr[p]];
        end else if ({1'b0, w_addr[p]} == c_BIDX_EXT) begin
          w_val[p] = r_block_idx;
        end else if ({1'b0, w_addr[p]} == c_BDIM_EXT) begin
          w_val[p] = c_BLOCK_DIM;
        end else if ({1'b0, w_addr[p]} == c_TIDX_EXT) begin
          w_val[p] = c_THREAD_IDX;
        end
      end
    end

    always_comb begin
      w_wdata = '0;
      case (bus.decoded_reg_input_mux)
        c_MUX_ALU: w_wdata = bus.alu_out[t*DATA_BITS +: DATA_BITS];
        c_MUX_LSU: w_wdata = bus.lsu_out[t*DATA_BITS +: DATA_BITS];
        c_MUX_IMM: w_wdata = bus.decoded_immediate;
        default:   w_wdata = '0;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          r_regs[i] <= '0;
        end
        r_rs <= '0;
        r_rt <= '0;
      end else if (bus.block_start) begin
        r_rs <= r_rs;
      end else if (r_state == S_CLEAR) begin
        r_regs[r_cnt] <= '0;
      end else if (bus.thread_enable[t]) begin
        if (w_rd_en) begin
          r_rs <= w_val[0];
          r_rt <= w_val[1];
        end
        if (w_wr_en) begin
          r_regs[bus.decoded_rd_address] <= w_wdata;
        end
      end
    end

    assign bus.rs[t*DATA_BITS +: DATA_BITS] = r_rs;
    assign bus.rt[t*DATA_BITS +: DATA_BITS] = r_rt;
  end
endmodule
`default_nettype wire

// File: tb/tb_thread_regfile_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_thread_regfile_bank
// Brief    : Directed and randomized checks of the bank against an array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_thread_regfile_bank;
  localparam int T  = 4;
  localparam int D  = 8;
  localparam int N  = 16;
  localparam int B  = 8;
  localparam int AW = 4;
  localparam logic [2:0] c_REQ = 3'd3;
  localparam logic [2:0] c_UPD = 3'd6;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  thread_regfile_bank_if #(.THREADS_PER_BLOCK(T), .DATA_BITS(D), .NUM_REGS(N), .BLOCK_ID_BITS(B)) bus ();

  thread_regfile_bank #(.THREADS_PER_BLOCK(T), .DATA_BITS(D), .NUM_REGS(N), .BLOCK_ID_BITS(B)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: whole register file per lane including the read-only slots
  logic [D-1:0] m_reg [T][N];
  logic [D-1:0] m_rs  [T];
  logic [D-1:0] m_rt  [T];
  int m_phase;  // 0 idle, 1 clearing, 2 active
  int m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < T; t++) begin
      for (int i = 0; i < N; i++) m_reg[t][i] = '0;
      m_reg[t][N-2] = D'(T);
      m_reg[t][N-1] = D'(t);
      m_rs[t] = '0;
      m_rt[t] = '0;
    end
    m_phase = 0;
    m_cnt   = 0;
  endtask

  task automatic model_update();
    int rd;
    if (bus.block_start) begin
      for (int t = 0; t < T; t++) m_reg[t][N-3] = bus.block_id[D-1:0];
      m_phase = 1;
      m_cnt   = 0;
    end else if (m_phase == 1) begin
      for (int t = 0; t < T; t++) m_reg[t][m_cnt] = '0;
      m_cnt++;
      if (m_cnt == N - 3) m_phase = 2;
    end else if (m_phase == 2) begin
      rd = int'(bus.decoded_rd_address);
      for (int t = 0; t < T; t++) begin
        if (bus.thread_enable[t]) begin
          if (bus.core_state == c_REQ) begin
            m_rs[t] = m_reg[t][bus.decoded_rs_address];
            m_rt[t] = m_reg[t][bus.decoded_rt_address];
          end else if (bus.core_state == c_UPD && bus.decoded_reg_write_enable && rd < N - 3) begin
            case (bus.decoded_reg_input_mux)
              2'b00:   m_reg[t][rd] = bus.alu_out[t*D +: D];
              2'b01:   m_reg[t][rd] = bus.lsu_out[t*D +: D];
              2'b10:   m_reg[t][rd] = bus.decoded_immediate;
              default: ;
            endcase
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [T*D-1:0] ers;
    logic [T*D-1:0] ert;
    for (int t = 0; t < T; t++) begin
      ers[t*D +: D] = m_rs[t];
      ert[t*D +: D] = m_rt[t];
    end
    check("busy", 64'(bus.busy), 64'(m_phase == 1));
    check("ready", 64'(bus.ready), 64'(m_phase == 2));
    check("rs", 64'(bus.rs), 64'(ers));
    check("rt", 64'(bus.rt), 64'(ert));
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_update();
    #1;
    check_outputs();
  endtask

  task automatic drive_idle();
    bus.thread_enable            = '1;
    bus.block_start              = 1'b0;
    bus.core_state               = 3'd0;
    bus.decoded_reg_write_enable = 1'b0;
    bus.decoded_reg_input_mux    = 2'b11;
  endtask

  task automatic req(input int a, input int b, input logic [T-1:0] en);
    bus.core_state         = c_REQ;
    bus.decoded_rs_address = AW'(a);
    bus.decoded_rt_address = AW'(b);
    bus.thread_enable      = en;
    step();
    drive_idle();
  endtask

  task automatic upd(input int rd, input logic [1:0] mux, input logic [D-1:0] imm,
                     input logic [T-1:0] en, input logic [T*D-1:0] alu, input logic [T*D-1:0] lsu);
    bus.core_state               = c_UPD;
    bus.decoded_rd_address       = AW'(rd);
    bus.decoded_reg_write_enable = 1'b1;
    bus.decoded_reg_input_mux    = mux;
    bus.decoded_immediate        = imm;
    bus.thread_enable            = en;
    bus.alu_out                  = alu;
    bus.lsu_out                  = lsu;
    step();
    drive_idle();
  endtask

  task automatic blk(input logic [B-1:0] id);
    bus.block_start = 1'b1;
    bus.block_id    = id;
    step();
    drive_idle();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 40 && bus.busy; k++) begin
      n++;
      step();
    end
    check("ready_after_clear", 64'(bus.ready), 64'd1);
  endtask

  initial begin
    int n;
    int r;
    reset_n = 1'b0;
    drive_idle();
    bus.block_id           = '0;
    bus.decoded_rd_address = '0;
    bus.decoded_rs_address = '0;
    bus.decoded_rt_address = '0;
    bus.decoded_immediate  = '0;
    bus.alu_out            = '0;
    bus.lsu_out            = '0;
    model_reset();
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // IDLE ignores reads
    req(15, 14, '1);
    check("idle_rs", 64'(bus.rs), 64'd0);

    blk(8'd5);
    wait_ready(n);
    check("busy_len", 64'(n), 64'd13);
    req(13, 15, '1);
    check("bidx_rs", 64'(bus.rs), 64'h05050505);
    check("tidx_rt", 64'(bus.rt), 64'h03020100);

    upd(2, 2'b00, 8'h00, '1, {8'd40, 8'd30, 8'd20, 8'd10}, '0);
    req(2, 2, '1);
    check("alu_wr", 64'(bus.rs), 64'h281E140A);
    upd(2, 2'b10, 8'h7F, '1, '0, '0);
    req(2, 2, '1);
    check("imm_wr", 64'(bus.rs), 64'h7F7F7F7F);

    upd(3, 2'b01, 8'h00, 4'b0101, '0, {8'd4, 8'd3, 8'd2, 8'd1});
    req(3, 3, 4'b0101);
    check("en_rs_hold", 64'(bus.rs), 64'h7F037F01);
    req(3, 3, '1);
    check("lsu_en_wr", 64'(bus.rs), 64'h00030001);

    upd(14, 2'b10, 8'd9, '1, '0, '0);
    upd(2, 2'b11, 8'h55, '1, '0, '0);
    req(14, 2, '1);
    check("ro_drop", 64'(bus.rs), 64'h04040404);
    check("mux11_nowr", 64'(bus.rt), 64'h7F7F7F7F);

    // restart mid-clear
    blk(8'd3);
    repeat (4) step();
    blk(8'd7);
    wait_ready(n);
    check("restart_len", 64'(n), 64'd13);
    req(13, 2, '1);
    check("restart_bidx", 64'(bus.rs), 64'h07070707);
    check("restart_clr", 64'(bus.rt), 64'h00000000);

    // asynchronous reset mid-clear
    blk(8'd9);
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("async_busy", 64'(bus.busy), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    blk(8'd1);
    wait_ready(n);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      bus.core_state               = (r < 4) ? c_REQ : (r < 8) ? c_UPD : 3'($urandom);
      bus.thread_enable            = T'($urandom);
      bus.decoded_rs_address       = AW'($urandom);
      bus.decoded_rt_address       = AW'($urandom);
      bus.decoded_rd_address       = AW'($urandom);
      bus.decoded_reg_write_enable = 1'($urandom);
      bus.decoded_reg_input_mux    = 2'($urandom);
      bus.decoded_immediate        = D'($urandom);
      bus.alu_out                  = (T*D)'($urandom);
      bus.lsu_out                  = (T*D)'($urandom);
      bus.block_id                 = B'($urandom);
      bus.block_start              = ($urandom_range(0, 39) == 0);
      step();
    end
    drive_idle();
    wait_ready(n);
    for (int a = 0; a < N; a++) req(a, N - 1 - a, '1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
